// File: rtl/rf_alu_pipe.sv
// rf_alu_pipe: two-stage LEGv8 register file + ALU.
// IS stage reads the RF (with one-cycle forwarding from EX) and decodes the
// ALU operation; EX stage computes result/flags, registers them to the outputs
// and writes back to the RF on the same edge.
module rf_alu_pipe #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [10:0]      OpCodefield,
  input  logic [AW-1:0]    Read1,
  input  logic [AW-1:0]    Read2,
  input  logic [AW-1:0]    WriteReg,
  input  logic             RegWrite,
  input  logic [WIDTH-1:0] SEout,
  input  logic             ALUSrc_Select,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUresult,
  output logic [AW-1:0]    out_dest,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             op_err
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_EOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_ERR  = 4'b1111;

  localparam logic [AW-1:0] XZR = AW'(NREG - 1);

  logic [WIDTH-1:0] regs [NREG];

  logic             ex_valid;
  logic             ex_wr;
  logic [3:0]       ex_op;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [AW-1:0]    ex_dest;

  logic [3:0]       dec_op;
  logic [WIDTH-1:0] rf_a, rf_b, fwd_a, fwd_b, opnd_b;
  logic             fwd_ok;

  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  function automatic logic is_xzr(input logic [AW-1:0] a);
    return ZERO_REG && (a == XZR);
  endfunction

  // ALU control decode from main-control ALUOp and the opcode field
  always_comb begin
    dec_op = OP_ERR;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_PASS;
      2'b10: begin
        case (OpCodefield)
          11'b10001011000: dec_op = OP_ADD;
          11'b11001011000: dec_op = OP_SUB;
          11'b10001010000: dec_op = OP_AND;
          11'b10101010000: dec_op = OP_ORR;
          11'b11001010000: dec_op = OP_EOR;
          default:         dec_op = OP_ERR;
        endcase
      end
      default: dec_op = OP_ERR;
    endcase
  end

  // RF read, EX->IS forwarding (never from XZR), then B-source select
  always_comb begin
    rf_a   = is_xzr(Read1) ? '0 : regs[Read1];
    rf_b   = is_xzr(Read2) ? '0 : regs[Read2];
    fwd_ok = ex_valid && ex_wr && !is_xzr(ex_dest);
    fwd_a  = (fwd_ok && (ex_dest == Read1)) ? alu_res : rf_a;
    fwd_b  = (fwd_ok && (ex_dest == Read2)) ? alu_res : rf_b;
    opnd_b = ALUSrc_Select ? SEout : fwd_b;
  end

  // EX-stage ALU: SUB is A + ~B + 1 sharing the adder with ADD
  always_comb begin
    b_in    = (ex_op == OP_SUB) ? ~ex_b : ex_b;
    sum     = {1'b0, ex_a} + {1'b0, b_in} + {{WIDTH{1'b0}}, (ex_op == OP_SUB)};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ex_op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (ex_a[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != ex_a[WIDTH-1]);
      end
      OP_AND:  alu_res = ex_a & ex_b;
      OP_ORR:  alu_res = ex_a | ex_b;
      OP_EOR:  alu_res = ex_a ^ ex_b;
      OP_PASS: alu_res = ex_b;
      default: alu_res = '0;
    endcase
  end

  // IS->EX pipeline register; error ops have their write enable masked here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_wr    <= 1'b0;
      ex_op    <= OP_ADD;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_dest  <= '0;
    end else begin
      ex_valid <= in_valid;
      ex_wr    <= RegWrite && (dec_op != OP_ERR);
      ex_op    <= dec_op;
      ex_a     <= fwd_a;
      ex_b     <= opnd_b;
      ex_dest  <= WriteReg;
    end
  end

  // Output registers; everything except out_valid holds through bubbles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ALUresult <= '0;
      out_dest  <= '0;
      Zero      <= 1'b1;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      out_valid <= ex_valid;
      if (ex_valid) begin
        ALUresult <= alu_res;
        out_dest  <= ex_dest;
        Zero      <= (alu_res == '0);
        Negative  <= alu_res[WIDTH-1];
        Carry     <= alu_c;
        Overflow  <= alu_v;
        op_err    <= (ex_op == OP_ERR);
      end
    end
  end

  // Register file: the writeback is assigned last so it beats a same-address preload
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (ld_en && !is_xzr(ld_addr)) regs[ld_addr] <= ld_data;
      if (ex_valid && ex_wr && !is_xzr(ex_dest)) regs[ex_dest] <= alu_res;
    end
  end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Bench for rf_alu_pipe: a 64-bit/32-reg and a 16-bit/8-reg instance share one
// stimulus stream (narrow instance sees the low bits). Each instance has an
// architectural reference model: every op executes in program order against a
// plain register array, which forwarding must make the pipeline equivalent to.
module tb_rf_alu_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [10:0] opc;
  logic [4:0]  r1, r2, wr;
  logic        rw;
  logic [63:0] se;
  logic        src;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [63:0] ld_data;

  logic        ov64, z64, n64, c64, v64, e64;
  logic [63:0] res64;
  logic [4:0]  dest64;
  logic        ov16, z16, n16, c16, v16, e16;
  logic [15:0] res16;
  logic [2:0]  dest16;

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;
  localparam logic [10:0] EOR = 11'b11001010000;

  rf_alu_pipe #(.WIDTH(64), .NREG(32), .ZERO_REG(1'b1)) u64 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .ALUOp(aluop),
    .OpCodefield(opc), .Read1(r1), .Read2(r2), .WriteReg(wr), .RegWrite(rw),
    .SEout(se), .ALUSrc_Select(src), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .out_valid(ov64), .ALUresult(res64), .out_dest(dest64),
    .Zero(z64), .Negative(n64), .Carry(c64), .Overflow(v64), .op_err(e64));

  rf_alu_pipe #(.WIDTH(16), .NREG(8), .ZERO_REG(1'b1)) u16 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .ALUOp(aluop),
    .OpCodefield(opc), .Read1(r1[2:0]), .Read2(r2[2:0]), .WriteReg(wr[2:0]),
    .RegWrite(rw), .SEout(se[15:0]), .ALUSrc_Select(src), .ld_en(ld_en),
    .ld_addr(ld_addr[2:0]), .ld_data(ld_data[15:0]), .out_valid(ov16),
    .ALUresult(res16), .out_dest(dest16), .Zero(z16), .Negative(n16),
    .Carry(c16), .Overflow(v16), .op_err(e16));

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [63:0] res;
    logic [4:0]  dest;
    logic        z, n, c, v, err;
  } exp_t;

  int          W [2] = '{64, 16};
  int          N [2] = '{32, 8};
  logic [63:0] mrf [2][32];
  exp_t        last [2];
  exp_t        pend [2];
  logic        pend_v;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mask_of(input int w);
    logic [63:0] m;
    m = '1;
    if (w < 64) m = (64'd1 << w) - 64'd1;
    return m;
  endfunction

  function automatic logic signed [65:0] sx(input logic [63:0] v, input int w);
    logic signed [65:0] t;
    t = $signed({2'b00, v});
    t = t <<< (66 - w);
    return t >>> (66 - w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) mrf[i][r] = '0;
      last[i] = '{valid: 1'b0, res: '0, dest: '0, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0};
    end
    pend_v = 1'b0;
  endtask

  // Executes the currently driven instruction on instance i's architectural state
  task automatic model_issue(input int i, output exp_t e);
    logic [63:0] m, a, b, res;
    int unsigned xz, ia, ib, iw;
    logic signed [65:0] ss, maxv, minv;
    logic c, v, err, arith;
    m  = mask_of(W[i]);
    xz = N[i] - 1;
    ia = r1 % N[i];
    ib = r2 % N[i];
    iw = wr % N[i];
    a  = (ia == xz) ? 64'd0 : mrf[i][ia];
    b  = src ? (se & m) : ((ib == xz) ? 64'd0 : mrf[i][ib]);
    maxv = (66'sd1 <<< (W[i] - 1)) - 66'sd1;
    minv = -maxv - 66'sd1;
    c = 1'b0; v = 1'b0; err = 1'b0; res = '0; arith = 1'b0; ss = '0;
    if (aluop == 2'b00 || (aluop == 2'b10 && opc == ADD)) begin
      res = (a + b) & m;
      c   = ({2'b00, a} + {2'b00, b}) > {2'b00, m};
      ss  = sx(a, W[i]) + sx(b, W[i]);
      arith = 1'b1;
    end else if (aluop == 2'b10 && opc == SUB) begin
      res = (a - b) & m;
      c   = (a >= b);
      ss  = sx(a, W[i]) - sx(b, W[i]);
      arith = 1'b1;
    end else if (aluop == 2'b01) res = b;
    else if (aluop == 2'b10 && opc == AND) res = a & b;
    else if (aluop == 2'b10 && opc == ORR) res = a | b;
    else if (aluop == 2'b10 && opc == EOR) res = a ^ b;
    else err = 1'b1;
    if (arith) v = (ss > maxv) || (ss < minv);
    e.valid = 1'b1;
    e.res   = res;
    e.dest  = 5'(iw);
    e.z     = (res == 64'd0);
    e.n     = res[W[i] - 1];
    e.c     = c;
    e.v     = v;
    e.err   = err;
    if (!err && rw && iw != xz) mrf[i][iw] = res;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/64.valid"}, ov64, last[0].valid);
    chk({tag, "/64.res"}, res64, last[0].res);
    chk({tag, "/64.dest"}, dest64, last[0].dest);
    chk({tag, "/64.flags"}, {z64, n64, c64, v64, e64},
        {last[0].z, last[0].n, last[0].c, last[0].v, last[0].err});
    chk({tag, "/16.valid"}, ov16, last[1].valid);
    chk({tag, "/16.res"}, res16, last[1].res);
    chk({tag, "/16.dest"}, dest16, last[1].dest);
    chk({tag, "/16.flags"}, {z16, n16, c16, v16, e16},
        {last[1].z, last[1].n, last[1].c, last[1].v, last[1].err});
  endtask

  // One clock: model the issue (if any), apply preload, then check outputs
  task automatic tick(input string tag);
    exp_t e [2];
    for (int i = 0; i < 2; i++) begin
      e[i] = last[i];
      if (in_valid) model_issue(i, e[i]);
      if (ld_en && (ld_addr % N[i]) != N[i] - 1)
        mrf[i][ld_addr % N[i]] = ld_data & mask_of(W[i]);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pend_v) last[i] = pend[i];
      else last[i].valid = 1'b0;
      pend[i] = e[i];
    end
    pend_v = in_valid;
    check_all(tag);
  endtask

  task automatic op(input logic [1:0] ao, input logic [10:0] oc, input logic [4:0] a1,
                    input logic [4:0] a2, input logic [4:0] d, input logic w,
                    input logic [63:0] s, input logic sr, input string tag);
    in_valid = 1'b1; aluop = ao; opc = oc; r1 = a1; r2 = a2; wr = d;
    rw = w; se = s; src = sr; ld_en = 1'b0;
    tick(tag);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0; ld_en = 1'b0;
    tick(tag);
  endtask

  // Leading bubble keeps a preload from colliding with an in-flight writeback
  task automatic preload(input logic [4:0] addr, input logic [63:0] data);
    idle("pl_drain");
    in_valid = 1'b0; ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick("preload");
    ld_en = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; aluop = '0; opc = '0; r1 = '0; r2 = '0; wr = '0; rw = 1'b0;
    se = '0; src = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    check_all("reset");
    for (int k = 0; k < 3; k++) idle("idle");
    chk("idle_res", res64, 64'd0);
    chk("idle_zero", z64, 1'b1);

    // every register reads back zero after reset
    for (int r = 0; r < 32; r++) op(2'b00, '0, 5'(r), 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, "rd_rst");
    idle("drain");

    // forwarded ADD then SUB
    preload(5'd1, 64'd5);
    preload(5'd2, 64'd3);
    op(2'b10, ADD, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 1'b0, "add");
    op(2'b10, SUB, 5'd3, 5'd1, 5'd4, 1'b1, 64'd0, 1'b0, "sub");
    chk("add_res", res64, 64'd8);
    chk("add_res16", res16, 16'd8);
    idle("sub_out");
    chk("sub_res", res64, 64'd3);
    chk("sub_carry", c64, 1'b1);
    op(2'b00, '0, 5'd4, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, "rd_x4");
    idle("rd_x4_out");
    chk("x4_val", res64, 64'd3);

    // 0 - 1 and signed overflow boundaries
    op(2'b10, SUB, 5'd5, 5'd0, 5'd6, 1'b1, 64'd1, 1'b1, "sub01");
    idle("sub01_out");
    chk("sub01_res", res64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub01_nzcv", {n64, c64, v64}, 3'b100);
    preload(5'd7, 64'h7FFF_FFFF_FFFF_FFFF);
    op(2'b10, ADD, 5'd7, 5'd0, 5'd8, 1'b1, 64'd1, 1'b1, "ovf");
    idle("ovf_out");
    chk("ovf_nv", {n64, v64}, 2'b11);

    // XZR: write dropped, never forwarded
    op(2'b10, ADD, 5'd1, 5'd0, 5'd31, 1'b1, 64'd4, 1'b1, "xzr_wr");
    op(2'b10, ADD, 5'd31, 5'd0, 5'd9, 1'b1, 64'd0, 1'b1, "xzr_dep");
    chk("xzr_res", res64, 64'd9);
    idle("xzr_dep_out");
    chk("xzr_nofwd", res64, 64'd0);

    // undecodable opcode with RegWrite: no write to X1
    op(2'b10, 11'b11111111111, 5'd2, 5'd2, 5'd1, 1'b1, 64'd0, 1'b0, "err");
    idle("err_out");
    chk("err_flag", e64, 1'b1);
    chk("err_res", res64, 64'd0);
    op(2'b00, '0, 5'd1, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, "rd_x1");
    idle("rd_x1_out");
    chk("x1_kept", res64, 64'd5);

    // reset while an ADD sits in EX
    op(2'b10, ADD, 5'd1, 5'd2, 5'd10, 1'b1, 64'd0, 1'b0, "pre_rst");
    in_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("in_rst");
    @(posedge clock);
    #3 reset = 1'b0;
    idle("post_rst");
    op(2'b00, '0, 5'd10, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, "rd_x10");
    idle("rd_x10_out");
    chk("x10_clear", res64, 64'd0);

    // ADD/SUB scenario again after reset
    preload(5'd1, 64'd5);
    preload(5'd2, 64'd3);
    op(2'b10, ADD, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 1'b0, "add2");
    op(2'b10, SUB, 5'd3, 5'd1, 5'd4, 1'b1, 64'd0, 1'b0, "sub2");
    idle("sub2_out");
    chk("sub2_res16", res16, 16'd3);
    chk("sub2_c16", c16, 1'b1);

    // randomized traffic against the architectural model
    for (int k = 0; k < 400; k++) begin
      int unsigned sel;
      logic [10:0] oc;
      logic [1:0]  ao;
      sel = $urandom_range(0, 19);
      if (sel == 0) preload(5'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 24 : 0)),
                            {$urandom, $urandom});
      else if (sel < 5) idle("rnd_idle");
      else begin
        sel = $urandom_range(0, 9);
        ao  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
        case ($urandom_range(0, 5))
          0: oc = ADD;
          1: oc = SUB;
          2: oc = AND;
          3: oc = ORR;
          4: oc = EOR;
          default: oc = 11'($urandom);
        endcase
        op(ao, oc,
           5'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 24 : 0)),
           5'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 24 : 0)),
           5'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 24 : 0)),
           1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? 64'(1 << $urandom_range(0, 3)) : {$urandom, $urandom},
           1'($urandom_range(0, 2) == 0), "rnd");
      end
    end
    idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_alu_pipe.md
# rf_alu_pipe

Parametrised, two-stage pipelined register file plus ALU for the LEGv8 datapath. It replaces the flat single-cycle RF/ALU pairing with a registered execute stage, an internal ALU control decoder, and one-cycle forwarding. It adds an XZR zero register, N/Z/C/V flags, and a bench/boot preload port. It sits between decode (control, sign-extend) and the memory/branch stages.

## Interface
- WIDTH, 64, datapath width in bits (≥8)
- NREG, 32, register count (power of two); AW = clog2(NREG)
- ZERO_REG, 1, when 1 register NREG-1 (XZR) reads 0 and ignores writes
- clock  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  issue an instruction this cycle
- ALUOp  in  2  main-control ALU op
- OpCodefield  in  11  instruction[31:21]
- Read1, Read2  in  AW  source register addresses
- WriteReg  in  AW  destination register
- RegWrite  in  1  write result to WriteReg
- SEout  in  WIDTH  sign-extended immediate
- ALUSrc_Select  in  1  0: B = R[Read2]; 1: B = SEout
- ld_en  in  1  preload write strobe
- ld_addr  in  AW  preload address
- ld_data  in  WIDTH  preload data
- out_valid  out  1  result registers hold a completed op
- ALUresult  out  WIDTH  registered result
- out_dest  out  AW  destination of the completed op
- Zero, Negative, Carry, Overflow  out  1 each  registered flags
- op_err  out  1  completed op had an undecodable opcode

## Operation
- Stage IS (issue cycle): combinational RF read of Read1/Read2, forwarding mux, B-source mux; operands, decoded ALUoperation, WriteReg, RegWrite, and in_valid are captured into the EX register at the clock edge.
- Stage EX: ALU computes from the EX register. At the next edge, the result and flags are registered to the outputs, out_valid takes the EX valid bit, and the register-file write occurs if EX valid & RegWrite.
- ALU control: ALUOp 00 gives ADD (0010). ALUOp 01 gives PASS B (0111). ALUOp 11 is an error. ALUOp 10 decodes OpCodefield:
  - 10001011000 ADD (0010)
  - 11001011000 SUB (0110)
  - 10001010000 AND (0000)
  - 10101010000 ORR (0001)
  - 11001010000 EOR (0011)
  - anything else is an error (1111)
- Error op: result 0, op_err=1, no register write (RegWrite is masked).
- Arithmetic is modulo 2^WIDTH. SUB = A + ~B + 1.
- Carry is the carry-out of bit WIDTH-1. Overflow is signed overflow. For logic/PASS ops, C=V=0.
- Zero = (result==0). Negative = result[WIDTH-1].
- Forwarding: for each source, if EX valid & EX RegWrite & EX dest==source & dest≠XZR, the source takes the EX ALU result instead of the RF value. The forwarded value passes through the B-source mux normally.
- XZR (ZERO_REG=1): reads of NREG-1 return 0, writes and preloads to it are dropped, and it is never forwarded.
- Preload: ld_en writes ld_data to ld_addr at the edge.
  - Preload data is not forwarded.
  - If a preload and a writeback target the same address at the same edge, the writeback wins.
- Reads of an address written at edge k see the new value from cycle k onward (RF read is after the edge, not bypassed within the write edge itself beyond the forwarding path above).

## Timing
- Latency: an op issued with in_valid sampled at edge k appears on the outputs (out_valid=1) after edge k+1. Its register write also lands at edge k+1.
- Throughput: one op per cycle, no stalls, no backpressure.
- Back-to-back dependency (issue k, dependent issue k+1) is resolved by forwarding. An issue at k+2 or later reads the updated RF directly.
- in_valid=0 cycles insert bubbles. Outputs other than out_valid hold their last values during bubbles.
- Reset (async, any time) clears:
  - all registers to 0
  - EX valid, out_valid, and op_err to 0
  - ALUresult and out_dest to 0
  - Negative, Carry, and Overflow to 0; Zero is set to 1

  In-flight ops are discarded and nothing is written. The first issue is accepted at the first edge with reset low.

## Test plan
- Reset then idle 3 cycles: out_valid=0, ALUresult=0, Zero=1, and a read of every register yields 0.
- Preload X1=5, X2=3. Issue ADD X3=X1+X2, then SUB X4=X3−X1 at the next cycle (forwarded): ALUresult sequence 8 then 3, X4=3, Carry=1 on the SUB.
- SUB of 0 − 1 (WIDTH=64) gives 0xFFFF…FFFF, Negative=1, Carry=0, Overflow=0. ADD 0x7FFF…FFFF + 1 gives Overflow=1, Negative=1.
- ADD into X31 with result 9: ALUresult=9. A later read of X31 returns 0, and a dependent issue at the next cycle is not forwarded (sees 0).
- ALUOp=10 with OpCodefield=11111111111 and RegWrite=1: op_err=1, result 0, destination unchanged.
- Assert reset for one cycle while an ADD is in EX: no write occurs, out_valid stays 0. Rerun the ADD/SUB scenario at WIDTH=16, NREG=8 and check identical results mod 2^16.
